// File: rtl/pwm_dimmer_array_if.sv
// Duty-write channel of the PWM dimmer array.
// The controller drives the master side and the dimmer drives the slave side.
interface pwm_dimmer_array_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 4
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_duty;
  logic             wr_fade;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_duty,
    output wr_fade,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_duty,
    input  wr_fade,
    output wr_ready
  );
endinterface

// File: rtl/pwm_dimmer_array.sv
// Multi-channel PWM dimmer. Duty writes land in a per-channel target and are
// applied to the active duty only at frame boundaries, either as a jump or as a fade.
module pwm_dimmer_array #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 4,
  parameter int PERIOD    = 5,
  parameter int FADE_STEP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  pwm_dimmer_array_if.slave   wr,
  output logic [CHANNELS-1:0] pwm_o,
  output logic [CHANNELS-1:0] busy,
  output logic                frame_start
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);
  localparam logic [WIDTH-1:0] LAST_W   = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(FADE_STEP);

  logic [WIDTH-1:0]    cnt;
  logic                boundary;
  logic                wrHit;
  logic                chOk;
  logic [WIDTH-1:0]    dutyClamped;
  logic [WIDTH-1:0]    active     [CHANNELS];
  logic [WIDTH-1:0]    target     [CHANNELS];
  logic [WIDTH-1:0]    nextActive [CHANNELS];
  logic [WIDTH-1:0]    diff       [CHANNELS];
  logic [CHANNELS-1:0] mode;

  assign boundary    = (cnt == LAST_W);
  assign wrHit       = wr.wr_valid && wr.wr_ready;
  assign chOk        = (32'(wr.wr_ch) < CHANNELS);
  assign dutyClamped = (wr.wr_duty > PERIOD_W) ? PERIOD_W : wr.wr_duty;
  assign frame_start = (cnt == '0);

  // Fade moves by at most STEP_W; the remaining distance caps the step so it never overshoots.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      nextActive[i] = active[i];
      diff[i]       = '0;
      if (!mode[i]) begin
        nextActive[i] = target[i];
      end else if (target[i] > active[i]) begin
        diff[i]       = target[i] - active[i];
        nextActive[i] = active[i] + ((diff[i] < STEP_W) ? diff[i] : STEP_W);
      end else if (target[i] < active[i]) begin
        diff[i]       = active[i] - target[i];
        nextActive[i] = active[i] - ((diff[i] < STEP_W) ? diff[i] : STEP_W);
      end
    end
  end

  always_comb begin
    pwm_o = '0;
    busy  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_o[i] = (cnt < active[i]);
      busy[i]  = (active[i] != target[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wr.wr_ready <= 1'b0;
    end else begin
      wr.wr_ready <= 1'b1;
      cnt         <= boundary ? '0 : cnt + 1'b1;
    end
  end

  // Boundary reads the targets held before this edge, so a same-edge write waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= '0;
        target[i] <= '0;
      end
      mode <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary) begin
          active[i] <= nextActive[i];
        end
        if (wrHit && chOk && (wr.wr_ch == CH_W'(i))) begin
          target[i] <= dutyClamped;
          mode[i]   <= wr.wr_fade;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_dimmer_array.sv
// Directed bench for pwm_dimmer_array: frame timing, clamping, fading,
// boundary-edge writes, out-of-range channels and asynchronous reset.
module tb_pwm_dimmer_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_dimmer_array_if #(.CHANNELS(4), .WIDTH(4)) busA ();
  pwm_dimmer_array_if #(.CHANNELS(3), .WIDTH(4)) busB ();

  logic [3:0] pwmA, busyA;
  logic       fsA;
  logic [2:0] pwmB, busyB;
  logic       fsB;

  pwm_dimmer_array #(.CHANNELS(4), .WIDTH(4), .PERIOD(5), .FADE_STEP(1)) dutA (
    .clk(clk), .rst_n(rst_n), .wr(busA.slave), .pwm_o(pwmA), .busy(busyA), .frame_start(fsA)
  );

  // Three channels leave wr_ch=3 encodable but out of range.
  pwm_dimmer_array #(.CHANNELS(3), .WIDTH(4), .PERIOD(5), .FADE_STEP(1)) dutB (
    .clk(clk), .rst_n(rst_n), .wr(busB.slave), .pwm_o(pwmB), .busy(busyB), .frame_start(fsB)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int d;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic toCnt(input int c);
    while (cyc % 5 != c) tick(1);
  endtask

  task automatic applyStimulus(input int ch, input int duty, input logic fade);
    busA.wr_valid = 1'b1;
    busA.wr_ch    = 2'(ch);
    busA.wr_duty  = 4'(duty);
    busA.wr_fade  = fade;
    tick(1);
    busA.wr_valid = 1'b0;
  endtask

  // Call at cnt==0; counts high cycles of one channel across the frame, ends at cnt==4.
  task automatic measureDuty(input int ch, output int duty);
    checkOutput("frame_start_at_measure", fsA, 1);
    duty = pwmA[ch];
    for (int k = 1; k < 5; k++) begin
      tick(1);
      duty += pwmA[ch];
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busA.wr_valid = 0; busA.wr_ch = 0; busA.wr_duty = 0; busA.wr_fade = 0;
    busB.wr_valid = 0; busB.wr_ch = 0; busB.wr_duty = 0; busB.wr_fade = 0;

    #20;
    checkOutput("rst_pwm", pwmA, 0);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_frame_start", fsA, 1);
    checkOutput("rst_ready", busA.wr_ready, 0);
    #2 rst_n = 1'b1;
    cyc = 0;
    checkOutput("release_ready", busA.wr_ready, 0);
    tick(1);
    checkOutput("ready_after_edge", busA.wr_ready, 1);
    for (int k = 0; k < 15; k++) begin
      checkOutput("idle_frame_start", fsA, (cyc % 5 == 0) ? 1 : 0);
      checkOutput("idle_pwm", pwmA, 0);
      checkOutput("idle_busy", busyA, 0);
      tick(1);
    end

    toCnt(1);
    applyStimulus(0, 3, 1'b0);
    checkOutput("ch0_busy_pending", busyA[0], 1);
    checkOutput("ch0_pwm_pending", pwmA[0], 0);
    toCnt(0);
    checkOutput("ch0_busy_cleared", busyA[0], 0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("ch0_pwm_duty3", pwmA[0], (cyc % 5 < 3) ? 1 : 0);
      tick(1);
    end

    toCnt(1);
    applyStimulus(1, 9, 1'b0);
    toCnt(0);
    measureDuty(1, d);
    checkOutput("ch1_clamped", d, 5);
    checkOutput("ch1_busy_clamped", busyA[1], 0);
    toCnt(1);
    applyStimulus(1, 0, 1'b0);
    toCnt(0);
    measureDuty(1, d);
    checkOutput("ch1_zero", d, 0);

    toCnt(1);
    applyStimulus(2, 5, 1'b1);
    checkOutput("ch2_busy_fade_start", busyA[2], 1);
    for (int s = 1; s <= 5; s++) begin
      toCnt(0);
      checkOutput("ch2_busy_during_up", busyA[2], (s != 5) ? 1 : 0);
      measureDuty(2, d);
      checkOutput("ch2_fade_up", d, s);
    end
    toCnt(1);
    applyStimulus(2, 2, 1'b1);
    for (int s = 4; s >= 2; s--) begin
      toCnt(0);
      measureDuty(2, d);
      checkOutput("ch2_fade_down", d, s);
    end
    checkOutput("ch2_busy_done", busyA[2], 0);

    toCnt(4);
    applyStimulus(3, 2, 1'b0);
    checkOutput("ch3_busy_after_edge_write", busyA[3], 1);
    measureDuty(3, d);
    checkOutput("ch3_old_duty_kept", d, 0);
    toCnt(0);
    measureDuty(3, d);
    checkOutput("ch3_new_duty", d, 2);
    toCnt(1);
    applyStimulus(3, 4, 1'b0);
    applyStimulus(3, 1, 1'b0);
    toCnt(0);
    measureDuty(3, d);
    checkOutput("ch3_last_write_wins", d, 1);

    toCnt(1);
    busB.wr_valid = 1'b1; busB.wr_ch = 2'd3; busB.wr_duty = 4'd5; busB.wr_fade = 1'b0;
    tick(1);
    busB.wr_valid = 1'b0;
    checkOutput("oor_busy", busyB, 0);
    toCnt(0);
    checkOutput("oor_pwm", pwmB, 0);
    checkOutput("oor_busy_boundary", busyB, 0);
    toCnt(1);
    busB.wr_valid = 1'b1; busB.wr_ch = 2'd2; busB.wr_duty = 4'd5; busB.wr_fade = 1'b0;
    tick(1);
    busB.wr_valid = 1'b0;
    toCnt(0);
    checkOutput("inrange_pwm", pwmB, 3'b100);

    toCnt(1);
    applyStimulus(2, 5, 1'b1);
    toCnt(0);
    tick(2);
    checkOutput("pre_rst_pwm2", pwmA[2], 1);
    checkOutput("pre_rst_pwm0", pwmA[0], 1);
    checkOutput("pre_rst_busy2", busyA[2], 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_pwm", pwmA, 0);
    checkOutput("async_rst_busy", busyA, 0);
    checkOutput("async_rst_frame_start", fsA, 1);
    checkOutput("async_rst_ready", busA.wr_ready, 0);
    #2 rst_n = 1'b1;
    cyc = 0;
    checkOutput("rerelease_ready", busA.wr_ready, 0);
    tick(1);
    checkOutput("rerelease_ready_edge", busA.wr_ready, 1);
    checkOutput("rerelease_frame_start", fsA, 0);
    toCnt(0);
    measureDuty(0, d);
    checkOutput("post_rst_ch0", d, 0);
    checkOutput("post_rst_busy", busyA, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
